// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer between the execute stage and a byte-enabled synchronous BRAM port.
// Steers store lanes, extends load data and optionally splits word-crossing accesses into two beats.
module lsu_access_sequencer #(
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_func3,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  // state | meaning
  // IDLE  | ready, waiting for a request
  // ACC0  | beat 0 driven to the BRAM
  // ACC1  | beat 0 read data captured, beat 1 driven
  // FIN   | last read data captured, load result formed
  // RESP  | one-cycle response pulse
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, FIN, RESP} state_t;
  state_t state;

  logic [3:0]            dec_base;
  logic                  dec_illegal;
  logic [7:0]            dec_mask8;
  logic                  dec_split;
  logic                  dec_err;
  logic [31:0]           dec_size_mask;
  logic [63:0]           dec_data64;

  logic                  lat_store;
  logic [2:0]            lat_func3;
  logic [1:0]            lat_off;
  logic [7:0]            lat_mask8;
  logic [63:0]           lat_data64;
  logic [ADDR_WIDTH-3:0] lat_waddr;
  logic [ADDR_WIDTH-3:0] lat_waddr1;
  logic                  lat_split;
  logic [31:0]           lo_word;

  logic [63:0]           ld_pair;
  logic [31:0]           ld_word;
  logic [31:0]           ld_ext;

  always_comb begin
    dec_base    = 4'b0000;
    dec_illegal = 1'b0;
    case (req_func3)
      3'b000:  dec_base = 4'b0001;
      3'b001:  dec_base = 4'b0011;
      3'b010:  dec_base = 4'b1111;
      3'b100: begin
        dec_base    = 4'b0001;
        dec_illegal = req_is_store;
      end
      3'b101: begin
        dec_base    = 4'b0011;
        dec_illegal = req_is_store;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_mask8     = {4'b0000, dec_base} << req_addr[1:0];
  assign dec_split     = |dec_mask8[7:4];
  assign dec_err       = dec_illegal | (dec_split & ~ALLOW_MISALIGNED);
  assign dec_size_mask = {{8{dec_base[3]}}, {8{dec_base[2]}}, {8{dec_base[1]}}, {8{dec_base[0]}}};
  assign dec_data64    = {32'd0, req_wdata & dec_size_mask} << {req_addr[1:0], 3'b000};

  // Beat 1 wraps from the top word back to word 0.
  assign lat_waddr1 = lat_waddr + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  // Reset suppresses a beat in flight so an aborted access commits nothing further.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!rst) begin
      case (state)
        ACC0: begin
          mem_en    = 1'b1;
          mem_we    = lat_store ? lat_mask8[3:0] : 4'b0000;
          mem_addr  = lat_waddr;
          mem_wdata = lat_data64[31:0];
        end
        ACC1: begin
          mem_en    = 1'b1;
          mem_we    = lat_store ? lat_mask8[7:4] : 4'b0000;
          mem_addr  = lat_waddr1;
          mem_wdata = lat_data64[63:32];
        end
        default: ;
      endcase
    end
  end

  assign ld_pair = lat_split ? {mem_rdata, lo_word} : {32'd0, mem_rdata};
  assign ld_word = ld_pair[{lat_off, 3'b000} +: 32];

  always_comb begin
    ld_ext = 32'd0;
    case (lat_func3)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  ld_ext = ld_word;
      3'b100:  ld_ext = {24'd0, ld_word[7:0]};
      3'b101:  ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      lat_store  <= 1'b0;
      lat_func3  <= 3'b000;
      lat_off    <= 2'b00;
      lat_mask8  <= 8'd0;
      lat_data64 <= 64'd0;
      lat_waddr  <= '0;
      lat_split  <= 1'b0;
      lo_word    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_store  <= req_is_store;
            lat_func3  <= req_func3;
            lat_off    <= req_addr[1:0];
            lat_mask8  <= dec_mask8;
            lat_data64 <= req_is_store ? dec_data64 : 64'd0;
            lat_waddr  <= req_addr[ADDR_WIDTH-1:2];
            lat_split  <= dec_split;
            req_ready  <= 1'b0;
            if (dec_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACC0;
            end
          end
        end
        ACC0: state <= lat_split ? ACC1 : FIN;
        ACC1: begin
          lo_word <= mem_rdata;
          state   <= FIN;
        end
        FIN: begin
          resp_valid <= 1'b1;
          resp_rdata <= lat_store ? 32'd0 : ld_ext;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- Parametrised load/store sequencer between the execute stage and a byte-enabled synchronous BRAM data port.
- Decodes func3 into byte enables and positions store data in byte lanes.
- Extracts and sign- or zero-extends load data.
- Optionally splits misaligned halfword/word accesses into two consecutive word accesses. Otherwise it reports them as errors.
- Sits where the combinational store-lane decoder sat. It adds a req/resp handshake and multi-cycle sequencing.

Parameters:
- ADDR_WIDTH, 32, byte-address width. Memory word address is ADDR_WIDTH-2 bits.
- ALLOW_MISALIGNED, 0, 1 = split accesses that cross a word boundary into two beats; 0 = flag them as errors.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address (ALU result)
- req_func3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_wdata  in  32  store source register value
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  illegal func3 or disallowed misalignment; qualified by resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_en  out  1  BRAM port enable
- mem_we  out  4  BRAM byte write enables (0 for loads)
- mem_addr  out  ADDR_WIDTH-2  BRAM word address
- mem_wdata  out  32  lane-positioned store data
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_en

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - All request fields are latched on acceptance.
  - req_valid outside IDLE is ignored.
  - resp_valid is a single-cycle pulse with no backpressure.
- Decode at acceptance:
  - Size: b/bu = 1 byte, h/hu = 2, w = 4.
  - Illegal: func3 011, 110, 111; store with 100 or 101.
  - off = addr[1:0]; base mask = 0001 / 0011 / 1111 by size.
  - mask8 = base << off.
  - Split when mask8[7:4] != 0.
  - Split with ALLOW_MISALIGNED = 0 is an error.
- Store data:
  - Take req_wdata masked to the access size, zero-extended to 64 bits, and shift left by off*8.
  - Beat 0 uses the low 32 bits and mask8[3:0].
  - Beat 1 uses the high 32 bits and mask8[7:4].
- Word addresses:
  - Beat 0 address = addr[ADDR_WIDTH-1:2].
  - Beat 1 address = beat 0 address + 1, wrapping modulo 2^(ADDR_WIDTH-2) (top word wraps to 0).
- State machine, with mem_* driven combinationally from state and latched fields:
  - IDLE:
    - On accept with error, go to RESP.
    - Otherwise go to ACC0.
  - ACC0:
    - mem_en = 1, beat 0 address; we = beat 0 mask for stores, 0 for loads.
    - Go to ACC1 if split, else FIN.
  - ACC1:
    - Capture mem_rdata as low word.
    - Drive beat 1 (mem_en = 1, beat 1 address and mask).
    - Go to FIN.
  - FIN:
    - Capture mem_rdata, as the high word if split, else as the low word.
    - Go to RESP.
  - RESP:
    - resp_valid = 1.
    - Return to IDLE.
- Load extraction:
  - Form {hi, lo} (hi = 0 if not split), shift right by off*8, take size bytes.
  - b/h sign-extend from bit 7/15; bu/hu zero-extend; w passes through.
- Latency, measured from accept cycle T to resp_valid:
  - Error: T+1.
  - Unsplit: T+3.
  - Split: T+4.
- Error responses: resp_err = 1, resp_rdata = 0, mem_en never asserted.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - No response is emitted for the aborted request.
  - A beat already written in a previous cycle remains committed.
- Back-to-back: a new request can be accepted the cycle after RESP.

Test Plan:
1. lw 0x10 (BRAM word 4 = 0xDEADBEEF) -> mem_en at T+1 with addr 4, we 0000; resp_valid at T+3, rdata 0xDEADBEEF, err 0.
2. lb 0x13 with word 4 = 0x80FF0011 -> rdata 0xFFFFFF80. lbu 0x13 -> 0x00000080. lh 0x12 -> 0xFFFF80FF.
3. sb 0x05, wdata 0x123456A7 -> single beat: addr 1, we 0010, wdata 0x0000A700; resp at T+3, rdata 0.
4. ALLOW_MISALIGNED = 1, sw 0x0E, wdata 0xAABBCCDD:
   - Beat 0: addr 3, we 1100, wdata 0xCCDD0000.
   - Beat 1: addr 4, we 0011, wdata 0x0000AABB.
   - resp at T+4.
   - A following lw 0x0E returns 0xAABBCCDD; lh 0x0F returns 0xFFFFBBCC.
5. ALLOW_MISALIGNED = 0, lh 0x07 -> resp_valid at T+1, err 1, rdata 0, mem_en never high. func3 = 011 -> same. sb with func3 100 -> same.
6. rst asserted during ACC1 of a split store -> next cycle IDLE: req_ready 1, mem_en 0; no resp_valid; beat 0 bytes written, beat 1 bytes unchanged.
